// File: rtl/airi5c_pcpi_master_if.sv
// rtl/airi5c_pcpi_master_if.sv - execute-stage request/response and PCPI bus bundle
interface airi5c_pcpi_master_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_insn;
  logic [XLEN-1:0] req_rs1;
  logic [XLEN-1:0] req_rs2;
  logic [XLEN-1:0] req_rs3;
  logic            kill;

  logic            resp_valid;
  logic            resp_ready;
  logic            resp_wr;
  logic [XLEN-1:0] resp_rd;
  logic [XLEN-1:0] resp_rd2;
  logic            resp_use_rd64;
  logic            resp_illegal;
  logic            resp_timeout;

  logic            pcpi_valid;
  logic [XLEN-1:0] pcpi_insn;
  logic [XLEN-1:0] pcpi_rs1;
  logic [XLEN-1:0] pcpi_rs2;
  logic [XLEN-1:0] pcpi_rs3;
  logic            pcpi_wr;
  logic [XLEN-1:0] pcpi_rd;
  logic [XLEN-1:0] pcpi_rd2;
  logic            pcpi_use_rd64;
  logic            pcpi_wait;
  logic            pcpi_ready;

  modport master (
    input  req_valid, req_insn, req_rs1, req_rs2, req_rs3, kill,
    output req_ready,
    output resp_valid, resp_wr, resp_rd, resp_rd2, resp_use_rd64, resp_illegal, resp_timeout,
    input  resp_ready,
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, pcpi_rs3,
    input  pcpi_wr, pcpi_rd, pcpi_rd2, pcpi_use_rd64, pcpi_wait, pcpi_ready
  );

  modport slave (
    output req_valid, req_insn, req_rs1, req_rs2, req_rs3, kill,
    input  req_ready,
    input  resp_valid, resp_wr, resp_rd, resp_rd2, resp_use_rd64, resp_illegal, resp_timeout,
    output resp_ready,
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, pcpi_rs3,
    output pcpi_wr, pcpi_rd, pcpi_rd2, pcpi_use_rd64, pcpi_wait, pcpi_ready
  );
endinterface

// File: rtl/airi5c_pcpi_master.sv
// rtl/airi5c_pcpi_master.sv - core-side PCPI initiator with ack timeout and busy watchdog
module airi5c_pcpi_master #(
  parameter int XLEN        = 32,
  parameter int ACK_TIMEOUT = 16,
  parameter int BUSY_LIMIT  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  airi5c_pcpi_master_if.master bus
);

  localparam int CNT_TOP = (ACK_TIMEOUT > BUSY_LIMIT) ? ACK_TIMEOUT : BUSY_LIMIT;
  localparam int CNT_W   = $clog2(CNT_TOP) + 1;
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'((BUSY_LIMIT > 0) ? BUSY_LIMIT - 1 : 0);
  localparam bit               WATCHDOG  = (BUSY_LIMIT > 0);

  typedef enum logic [2:0] {IDLE, ISSUE, BUSY, RESP, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [XLEN-1:0] insn_q, insn_d, rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d;
  logic [XLEN-1:0] rd_q, rd_d, rd2_q, rd2_d;
  logic            wr_q, wr_d, use_rd64_q, use_rd64_d;
  logic            illegal_q, illegal_d, timeout_q, timeout_d;
  logic            capture, fail_ack, fail_busy;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    insn_d     = insn_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rs3_d      = rs3_q;
    rd_d       = rd_q;
    rd2_d      = rd2_q;
    wr_d       = wr_q;
    use_rd64_d = use_rd64_q;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    capture    = 1'b0;
    fail_ack   = 1'b0;
    fail_busy  = 1'b0;
    cnt_inc    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          insn_d  = bus.req_insn;
          rs1_d   = bus.req_rs1;
          rs2_d   = bus.req_rs2;
          rs3_d   = bus.req_rs3;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // ready beats wait so a zero-wait coprocessor completes without entering BUSY
        if (bus.kill) begin
          state_d = IDLE;
        end else if (bus.pcpi_ready) begin
          capture = 1'b1;
        end else if (bus.pcpi_wait) begin
          cnt_d   = '0;
          state_d = BUSY;
        end else if (cnt_q == ACK_LAST) begin
          fail_ack = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      BUSY: begin
        // a killed but claimed instruction may still pulse ready later; DRAIN swallows it
        if (bus.kill) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else if (bus.pcpi_ready) begin
          capture = 1'b1;
        end else if (WATCHDOG && cnt_q == BUSY_LAST) begin
          fail_busy = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP: begin
        if (bus.resp_ready || bus.kill) state_d = IDLE;
      end
      DRAIN: begin
        if (bus.pcpi_ready || (WATCHDOG && cnt_q == BUSY_LAST)) state_d = IDLE;
        else cnt_d = cnt_inc;
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      wr_d       = bus.pcpi_wr;
      rd_d       = bus.pcpi_rd;
      rd2_d      = bus.pcpi_rd2;
      use_rd64_d = bus.pcpi_use_rd64;
      illegal_d  = 1'b0;
      timeout_d  = 1'b0;
      state_d    = RESP;
    end else if (fail_ack || fail_busy) begin
      wr_d       = 1'b0;
      rd_d       = '0;
      rd2_d      = '0;
      use_rd64_d = 1'b0;
      illegal_d  = fail_ack;
      timeout_d  = fail_busy;
      state_d    = RESP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      insn_q     <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rs3_q      <= '0;
      rd_q       <= '0;
      rd2_q      <= '0;
      wr_q       <= 1'b0;
      use_rd64_q <= 1'b0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      insn_q     <= insn_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rs3_q      <= rs3_d;
      rd_q       <= rd_d;
      rd2_q      <= rd2_d;
      wr_q       <= wr_d;
      use_rd64_q <= use_rd64_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.req_ready     = (state_q == IDLE);
  assign bus.pcpi_valid    = (state_q == ISSUE) || (state_q == BUSY);
  assign bus.resp_valid    = (state_q == RESP);
  assign bus.resp_wr       = wr_q;
  assign bus.resp_rd       = rd_q;
  assign bus.resp_rd2      = rd2_q;
  assign bus.resp_use_rd64 = use_rd64_q;
  assign bus.resp_illegal  = illegal_q;
  assign bus.resp_timeout  = timeout_q;
  assign bus.pcpi_insn     = insn_q;
  assign bus.pcpi_rs1      = rs1_q;
  assign bus.pcpi_rs2      = rs2_q;
  assign bus.pcpi_rs3      = rs3_q;

endmodule
